// File: rtl/ols_pkg.sv
// Shared widths, bf16 field constants and FSM encoding for output_layer_sched.
package ols_pkg;

   localparam int BF16_W     = 16;
   localparam int NRN_FANIN  = 10;
   localparam int VEC_W      = BF16_W * NRN_FANIN;
   localparam int BF16_EXP_W = 8;
   localparam int BF16_MAN_W = 7;
   localparam int BF16_SIGN  = BF16_W - 1;

   localparam logic [BF16_W-1:0] BF16_POS_ZERO = 16'h0000;
   localparam logic [BF16_W-1:0] BF16_NEG_ZERO = 16'h8000;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_LOAD    = 3'd2,
      ST_HOLD    = 3'd3,
      ST_CAPTURE = 3'd4,
      ST_DONE    = 3'd5
   } ols_state_t;

   // Magnitude (exponent + mantissa) of a bf16 word, sign stripped.
   function automatic logic [BF16_W-2:0] bf16_mag(input logic [BF16_W-1:0] v);
      return v[BF16_W-2:0];
   endfunction

endpackage

// File: rtl/bf16_gt.sv
// Combinational a > b in bf16 signed order (sign-magnitude, -0 equals +0).
module bf16_gt
   import ols_pkg::*;
(
   input  logic [BF16_W-1:0] a,
   input  logic [BF16_W-1:0] b,
   output logic              gt
);

   logic              sa;
   logic              sb;
   logic [BF16_W-2:0] ma;
   logic [BF16_W-2:0] mb;

   assign sa = a[BF16_SIGN];
   assign sb = b[BF16_SIGN];
   assign ma = bf16_mag(a);
   assign mb = bf16_mag(b);

   always_comb begin
      gt = 1'b0;
      if (ma == '0 && mb == '0) begin
         gt = 1'b0;
      end else if (sa != sb) begin
         gt = ~sa;
      end else if (!sa) begin
         gt = (ma > mb);
      end else begin
         // Both negative: the smaller magnitude is the larger value.
         gt = (ma < mb);
      end
   end

endmodule

// File: rtl/output_layer_sched.sv
// Time-multiplexes one external 10-input bf16 neuron across NUM_CLASSES output classes.
// Optional running argmax is built when OLS_ARGMAX_EN is defined.
module output_layer_sched
   import ols_pkg::*;
#(
   parameter int NUM_CLASSES = 10,
   parameter int HOLD_CYCLES = 5,
   parameter int ADDR_W      = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              ready,
   input  logic [VEC_W-1:0]  relu_in,
   input  logic              abort,
   output logic              wt_rd_en,
   output logic [ADDR_W-1:0] wt_addr,
   input  logic [VEC_W-1:0]  wt_rdata,
   output logic [VEC_W-1:0]  nrn_relu,
   output logic [VEC_W-1:0]  nrn_weight,
   input  logic [BF16_W-1:0] nrn_result,
   output logic              score_valid,
   output logic [BF16_W-1:0] score,
   output logic [7:0]        score_idx,
   output logic              done,
   output logic [7:0]        argmax_idx,
   output logic              argmax_valid
);

   localparam int              HC_W       = $clog2(HOLD_CYCLES + 1);
   localparam logic [HC_W-1:0] HOLD_LAST  = HC_W'(HOLD_CYCLES - 1);
   localparam logic [7:0]      LAST_CLASS = 8'(NUM_CLASSES - 1);

   ols_state_t      state;
   ols_state_t      state_nxt;
   logic [7:0]      class_idx;
   logic [HC_W-1:0] hold_cnt;
   logic            start_ok;
   logic            busy_abort;
   logic            score_pend;
   logic            done_q;

   assign start_ok   = (state == ST_IDLE) && start;
   assign busy_abort = (state != ST_IDLE) && abort;

   assign ready    = (state == ST_IDLE);
   assign wt_rd_en = (state == ST_FETCH);
   assign wt_addr  = wt_rd_en ? ADDR_W'(class_idx) : '0;

   // A registered score pulse is withheld if an abort lands in the cycle it would show.
   assign score_valid = score_pend && !busy_abort;
   assign done        = done_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (busy_abort) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:    if (start) state_nxt = ST_FETCH;
            ST_FETCH:   state_nxt = ST_LOAD;
            ST_LOAD:    state_nxt = ST_HOLD;
            ST_HOLD:    if (hold_cnt == HOLD_LAST) state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = (class_idx == LAST_CLASS) ? ST_DONE : ST_FETCH;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         class_idx  <= '0;
         hold_cnt   <= '0;
         nrn_relu   <= '0;
         nrn_weight <= '0;
         score      <= '0;
         score_idx  <= '0;
         score_pend <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         score_pend <= 1'b0;
         done_q     <= 1'b0;
         if (start_ok) begin
            nrn_relu  <= relu_in;
            class_idx <= '0;
         end
         if (!busy_abort) begin
            case (state)
               ST_LOAD: begin
                  nrn_weight <= wt_rdata;
                  hold_cnt   <= '0;
               end
               ST_HOLD: hold_cnt <= hold_cnt + 1'b1;
               ST_CAPTURE: begin
                  score      <= nrn_result;
                  score_idx  <= class_idx;
                  score_pend <= 1'b1;
                  if (class_idx != LAST_CLASS) class_idx <= class_idx + 8'd1;
               end
               ST_DONE: done_q <= 1'b1;
               default: ;
            endcase
         end
      end
   end

`ifdef OLS_ARGMAX_EN
   logic [BF16_W-1:0] best_val;
   logic [7:0]        best_idx;
   logic              new_gt;

   bf16_gt u_gt (
      .a  (nrn_result),
      .b  (best_val),
      .gt (new_gt)
   );

   // Strictly-greater replacement keeps the lowest index on ties.
   always_ff @(posedge clk) begin
      if (reset) begin
         best_val     <= BF16_POS_ZERO;
         best_idx     <= '0;
         argmax_idx   <= '0;
         argmax_valid <= 1'b0;
      end else begin
         if (start_ok) argmax_valid <= 1'b0;
         if (!busy_abort && state == ST_CAPTURE && (class_idx == '0 || new_gt)) begin
            best_val <= nrn_result;
            best_idx <= class_idx;
         end
         if (!busy_abort && state == ST_DONE) begin
            argmax_idx   <= best_idx;
            argmax_valid <= 1'b1;
         end
      end
   end
`else
   assign argmax_idx   = '0;
   assign argmax_valid = 1'b0;
`endif

endmodule

// File: tb/tb_output_layer_sched.sv
// Randomized bench for output_layer_sched with a weight RAM model and a 5-stage stub neuron.
module tb_output_layer_sched;
   import ols_pkg::*;

   localparam int NC  = 10;
   localparam int HC  = 5;
   localparam int AW  = 8;
   localparam int PER = HC + 3;
   localparam int LAT = NC * PER + 1;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              abort;
   logic              ready;
   logic [VEC_W-1:0]  relu_in;
   logic              wt_rd_en;
   logic [AW-1:0]     wt_addr;
   logic [VEC_W-1:0]  wt_rdata;
   logic [VEC_W-1:0]  nrn_relu;
   logic [VEC_W-1:0]  nrn_weight;
   logic [15:0]       nrn_result;
   logic              score_valid;
   logic [15:0]       score;
   logic [7:0]        score_idx;
   logic              done;
   logic [7:0]        argmax_idx;
   logic              argmax_valid;

   output_layer_sched #(.NUM_CLASSES(NC), .HOLD_CYCLES(HC), .ADDR_W(AW)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .ready        (ready),
      .relu_in      (relu_in),
      .abort        (abort),
      .wt_rd_en     (wt_rd_en),
      .wt_addr      (wt_addr),
      .wt_rdata     (wt_rdata),
      .nrn_relu     (nrn_relu),
      .nrn_weight   (nrn_weight),
      .nrn_result   (nrn_result),
      .score_valid  (score_valid),
      .score        (score),
      .score_idx    (score_idx),
      .done         (done),
      .argmax_idx   (argmax_idx),
      .argmax_valid (argmax_valid)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- environment: weight RAM and stub neuron ----------------
   logic [VEC_W-1:0] rows [NC];
   logic [15:0]      tbl  [NC];
   logic [15:0]      pipe [5];

   // Each row carries its class number in its low byte so the stub can pick a score.
   function automatic logic [15:0] stub_fn(input logic [VEC_W-1:0] r, input logic [VEC_W-1:0] w);
      logic [15:0] t;
      t = (int'(w[7:0]) < NC) ? tbl[w[7:0]] : 16'h0000;
      return t ^ r[15:0] ^ r[159:144] ^ w[159:144];
   endfunction

   always @(posedge clk) begin
      pipe[0] <= stub_fn(nrn_relu, nrn_weight);
      for (int i = 1; i < 5; i++) pipe[i] <= pipe[i-1];
      wt_rdata <= wt_rd_en ? rows[wt_addr] : {$urandom, $urandom, $urandom, $urandom, $urandom};
   end
   assign nrn_result = pipe[4];

   // ---------------- reference model ----------------
   function automatic logic [15:0] model_score(input logic [VEC_W-1:0] v, input int k);
      return tbl[k] ^ v[15:0] ^ v[159:144] ^ rows[k][159:144];
   endfunction

   // Signed ordering key: sign-magnitude to integer, so -0 and +0 map to 0.
   function automatic int bf_key(input logic [15:0] v);
      return v[15] ? -int'(v[14:0]) : int'(v[14:0]);
   endfunction

   function automatic int model_argmax(input logic [VEC_W-1:0] v);
      int best = 0;
      int bk   = bf_key(model_score(v, 0));
      for (int k = 1; k < NC; k++) begin
         if (bf_key(model_score(v, k)) > bk) begin
            best = k;
            bk   = bf_key(model_score(v, k));
         end
      end
      return best;
   endfunction

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   int               cyc      = 0;
   int               acc_cyc  = 0;
   int               rd_cnt   = 0;
   int               done_cnt = 0;
   logic [23:0]      exp_q [$];
   logic [VEC_W-1:0] prev_w;
   logic             rd_d1  = 1'b0;
   logic             rd_d2  = 1'b0;
   logic             rst_d1 = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      logic [23:0] e;
      check("sv_done_excl", {31'b0, score_valid & done}, 32'd0);
      if (wt_rd_en) rd_cnt++;
      if (score_valid) begin
         if (exp_q.size() == 0) begin
            check("score_unexpected", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("score_idx", score_idx, e[23:16]);
            check("score", score, e[15:0]);
            check("score_time", cyc - acc_cyc, PER * (int'(e[23:16]) + 1));
         end
      end
      if (done) begin
         done_cnt++;
         check("done_latency", cyc - acc_cyc, LAT);
         check("done_pending", exp_q.size(), 32'd0);
         check("rd_count", rd_cnt, NC);
      end
      // Weights may only move in the cycle after the load that follows a fetch.
      if (!reset && !rst_d1 && nrn_weight !== prev_w)
         check("weight_change_after_fetch", rd_d2, 32'd1);
      prev_w = nrn_weight;
      rd_d2  = rd_d1;
      rd_d1  = wt_rd_en;
      rst_d1 = reset;
   end

   // ---------------- driver tasks ----------------
   task automatic fill_rows(input bit zero_top);
      for (int k = 0; k < NC; k++) begin
         rows[k]      = {$urandom, $urandom, $urandom, $urandom, $urandom};
         rows[k][7:0] = 8'(k);
         if (zero_top) rows[k][159:144] = '0;
      end
   endtask

   task automatic fill_tbl_random();
      for (int k = 0; k < NC; k++) tbl[k] = 16'($urandom_range(0, 65535));
   endtask

   task automatic wait_ready();
      int i = 0;
      while (!ready && i < 200) begin
         @(negedge clk);
         i++;
      end
      check("ready_timeout", ready, 32'd1);
   endtask

   task automatic start_run(input logic [VEC_W-1:0] v, input bit with_abort);
      wait_ready();
      relu_in = v;
      start   = 1'b1;
      abort   = with_abort;
      @(posedge clk);
      #1;
      start   = 1'b0;
      abort   = 1'b0;
      relu_in = ~v;
      acc_cyc = cyc;
      rd_cnt  = 0;
      exp_q.delete();
      for (int k = 0; k < NC; k++) exp_q.push_back({8'(k), model_score(v, k)});
   endtask

   task automatic wait_done();
      int d0 = done_cnt;
      int i  = 0;
      while (done_cnt == d0 && i < LAT + 20) begin
         @(negedge clk);
         i++;
      end
      #1;
      check("done_seen", done_cnt, d0 + 1);
   endtask

   task automatic check_argmax(input int exp_idx);
`ifdef OLS_ARGMAX_EN
      check("argmax_valid", argmax_valid, 32'd1);
      check("argmax_idx", argmax_idx, exp_idx);
`else
      check("argmax_valid_off", argmax_valid, 32'd0);
      check("argmax_idx_off", argmax_idx, 32'd0);
      if (exp_idx < 0) $display("unexpected index");
`endif
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_ready"}, ready, 32'd1);
      check({tag, "_wt_rd_en"}, wt_rd_en, 32'd0);
      check({tag, "_wt_addr"}, wt_addr, 32'd0);
      check({tag, "_score_valid"}, score_valid, 32'd0);
      check({tag, "_score"}, score, 32'd0);
      check({tag, "_score_idx"}, score_idx, 32'd0);
      check({tag, "_done"}, done, 32'd0);
      check({tag, "_nrn_relu"}, {31'b0, nrn_relu == '0}, 32'd1);
      check({tag, "_nrn_weight"}, {31'b0, nrn_weight == '0}, 32'd1);
      check({tag, "_argmax_valid"}, argmax_valid, 32'd0);
      check({tag, "_argmax_idx"}, argmax_idx, 32'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [VEC_W-1:0] v;
      int               d0;

      reset   = 1'b1;
      start   = 1'b0;
      abort   = 1'b0;
      relu_in = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_idle_zero("reset");

      // Single run with all-ones ReLU vector.
      fill_rows(1'b0);
      fill_tbl_random();
      v = {NRN_FANIN{16'h3F80}};
      start_run(v, 1'b0);
      wait_done();
      check_argmax(model_argmax(v));

      // Argmax with a tie: the lower index must win.
      fill_rows(1'b1);
      for (int k = 0; k < NC; k++) tbl[k] = 16'h0000;
      tbl[0] = 16'h3F80; tbl[1] = 16'h4000; tbl[2] = 16'hBF80; tbl[3] = 16'h4000;
      start_run('0, 1'b0);
      wait_done();
      check_argmax(1);

      // Negative zero against positive zero does not replace class 0.
      for (int k = 0; k < NC; k++) tbl[k] = 16'h8000;
      tbl[4] = 16'h0000;
      start_run('0, 1'b0);
      wait_done();
      check_argmax(0);

      tbl[4] = 16'h3C00;
      start_run('0, 1'b0);
      wait_done();
      check_argmax(4);

      // Start while busy is ignored.
      fill_rows(1'b0);
      fill_tbl_random();
      v = {$urandom, $urandom, $urandom, $urandom, $urandom};
      start_run(v, 1'b0);
      repeat (20) @(posedge clk);
      #1;
      start   = 1'b1;
      relu_in = ~v;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("busy_relu_kept", {31'b0, nrn_relu == v}, 32'd1);
      check("busy_not_ready", ready, 32'd0);
      d0 = done_cnt;
      wait_done();
      repeat (LAT) @(negedge clk);
      check("busy_single_done", done_cnt, d0 + 1);

      // Abort during class 3 hold.
      v = {$urandom, $urandom, $urandom, $urandom, $urandom};
      start_run(v, 1'b0);
      repeat (30) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      check("abort_scores_left", exp_q.size(), NC - 3);
      exp_q.delete();
      @(negedge clk);
      check("abort_ready", ready, 32'd1);
      check("abort_relu_kept", {31'b0, nrn_relu == v}, 32'd1);
      d0 = done_cnt;
      repeat (LAT) @(negedge clk);
      check("abort_no_done", done_cnt, d0);
      check("abort_argmax_valid", argmax_valid, 32'd0);

      // Restart after abort, with abort raised alongside start (start wins).
      start_run(v, 1'b1);
      wait_done();
      check_argmax(model_argmax(v));

      // Reset mid-run.
      start_run({$urandom, $urandom, $urandom, $urandom, $urandom}, 1'b0);
      repeat (45) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check_idle_zero("midrst");

      // Randomized full runs.
      for (int r = 0; r < 4; r++) begin
         fill_rows(r[0]);
         fill_tbl_random();
         v = {$urandom, $urandom, $urandom, $urandom, $urandom};
         start_run(v, 1'b0);
         wait_done();
         check_argmax(model_argmax(v));
      end

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
